regfile_scoreboard: RTL and testbench

Integer register file with its writeback consumer side and a per-register pending-write scoreboard. It receives the selected writeback value (mem / ALU result / next PC, already muxed upstream) and commits it to the architectural registers. It serves the decode stage with two combinational read ports with same-cycle writeback bypass, and raises a stall whenever a decoded instruction depends on a register whose writeback is still in flight. Sits between the decode stage (read/issue side) and the writeback stage (write side) of the 5-stage pipeline.

---
 rtl/regfile_scoreboard.sv | 89 ++++++++
 tb/tb_regfile_scoreboard.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Integer register file with same-cycle writeback bypass and a per-register
// pending-write scoreboard that stalls decode on RAW and WAW hazards.
module regfile_scoreboard #(
  parameter int NREG = 32,
  parameter int XLEN = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            issue_we,
  input  logic            issue_use_rs1,
  input  logic            issue_use_rs2,
  output logic            stall,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [NREG-1:0] busy_vec
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] wb_hit;
  logic [NREG-1:0] eff_busy;
  logic            accept;

  // One-hot of the register the writeback stage is committing this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    wb_hit = '0;
    if (wb_en) wb_hit[wb_addr] = 1'b1;
  end

  // A writeback landing this cycle resolves the dependency on that register.
  assign eff_busy = busy_q & ~wb_hit;

  assign stall = issue_valid &&
                 ((issue_use_rs1 && eff_busy[rs1_addr]) ||
                  (issue_use_rs2 && eff_busy[rs2_addr]) ||
                  (issue_we      && eff_busy[issue_rd]));
  assign accept = issue_valid && !stall;

  always_comb begin
    rs1_data = regs_q[rs1_addr];
    if (rs1_addr == '0)                         rs1_data = '0;
    else if (wb_en && wb_addr == rs1_addr)      rs1_data = wb_data;

    rs2_data = regs_q[rs2_addr];
    if (rs2_addr == '0)                         rs2_data = '0;
    else if (wb_en && wb_addr == rs2_addr)      rs2_data = wb_data;
  end

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wb_en && wb_addr != '0) regs_d[wb_addr] = wb_data;
    for (int i = 1; i < NREG; i++) begin
      // Set beats clear: a new producer issued in the cycle the old one retires.
      if (accept && issue_we && issue_rd == AW'(i)) busy_d[i] = 1'b1;
      else if (wb_hit[i])                           busy_d[i] = 1'b0;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  // NOTE: the register array is reset because software-visible state must come
  // up as zero; a storage array normally would not be reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops
      // update from the same pre-edge values.
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, write/read, bypass, RAW/WAW
// stalls, set-over-clear and unused-source cases with hand-computed values.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, issue_rd, wb_addr;
  logic [31:0] rs1_data, rs2_data, wb_data, busy_vec;
  logic        issue_valid, issue_we, issue_use_rs1, issue_use_rs2;
  logic        stall, wb_en;

  int n_vec = 0;
  int n_err = 0;

  regfile_scoreboard dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_we(issue_we),
    .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
    .stall(stall),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_we = 1'b0; issue_rd = '0;
    issue_use_rs1 = 1'b0; issue_use_rs2 = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    rs1_addr = '0; rs2_addr = '0;
  endtask

  task automatic do_issue(input logic [4:0] rd);
    issue_valid = 1'b1; issue_we = 1'b1; issue_rd = rd;
    issue_use_rs1 = 1'b0; issue_use_rs2 = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #2;
    check("rst_busy", busy_vec, 32'h0);
    // Bypass still works while reset is held.
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h77; rs1_addr = 5'd2;
    issue_valid = 1'b1; issue_use_rs1 = 1'b1;
    #1;
    check("rst_bypass", rs1_data, 32'h77);
    check("rst_stall", {31'b0, stall}, 32'h0);
    idle();
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Write then read.
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
    tick();
    idle(); rs1_addr = 5'd5;
    #1 check("wr_rd_x5", rs1_data, 32'hDEAD_BEEF);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234; rs1_addr = 5'd0;
    #1 check("x0_bypass", rs1_data, 32'h0);
    tick();
    idle(); rs2_addr = 5'd0;
    #1 check("x0_read", rs2_data, 32'h0);

    // Bypass on port 2, with x7 holding an older value.
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h1111_1111;
    tick();
    wb_data = 32'hA5A5_A5A5; rs2_addr = 5'd7; rs1_addr = 5'd5;
    #1 check("byp_rs2", rs2_data, 32'hA5A5_A5A5);
    check("byp_rs1_other", rs1_data, 32'hDEAD_BEEF);
    tick();
    idle(); rs2_addr = 5'd7;
    #1 check("x7_after", rs2_data, 32'hA5A5_A5A5);

    // RAW stall.
    do_issue(5'd3);
    #1 check("raw_prod_stall", {31'b0, stall}, 32'h0);
    tick();
    idle();
    #1 check("raw_busy", busy_vec, 32'h8);
    issue_valid = 1'b1; issue_use_rs1 = 1'b1; rs1_addr = 5'd3;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("raw_stall%0d", i), {31'b0, stall}, 32'h1);
      tick();
    end
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'd42;
    #1 check("raw_wb_stall", {31'b0, stall}, 32'h0);
    check("raw_wb_data", rs1_data, 32'd42);
    tick();
    idle();
    #1 check("raw_busy_clr", busy_vec, 32'h0);

    // WAW guard and set-over-clear.
    do_issue(5'd4);
    tick();
    #1 check("waw_busy", busy_vec, 32'h10);
    check("waw_stall", {31'b0, stall}, 32'h1);
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h4;
    #1 check("waw_wb_stall", {31'b0, stall}, 32'h0);
    tick();
    idle();
    #1 check("set_wins", busy_vec, 32'h10);
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
    tick();
    idle();
    #1 check("waw_clr", busy_vec, 32'h0);
    do_issue(5'd0);
    #1 check("x0_issue_stall", {31'b0, stall}, 32'h0);
    tick();
    #1 check("x0_issue_busy", busy_vec, 32'h0);
    check("x0_again_stall", {31'b0, stall}, 32'h0);
    idle();

    // Unused sources.
    do_issue(5'd9);
    tick();
    idle();
    issue_valid = 1'b1; rs1_addr = 5'd9; rs2_addr = 5'd9;
    #1 check("unused_rs1", {31'b0, stall}, 32'h0);
    issue_use_rs1 = 1'b1;
    #1 check("used_rs1", {31'b0, stall}, 32'h1);
    issue_use_rs1 = 1'b0; issue_use_rs2 = 1'b1;
    #1 check("used_rs2", {31'b0, stall}, 32'h1);
    idle();

    // Mid-run reset with x1 and x2 pending.
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h9;
    do_issue(5'd1);
    tick();
    idle();
    do_issue(5'd2);
    tick();
    idle();
    #1 check("pre_rst_busy", busy_vec, 32'h6);
    rst = 1'b1;
    #1 check("rst_now_busy", busy_vec, 32'h0);
    rs1_addr = 5'd5;
    #1 check("rst_now_x5", rs1_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int r = 1; r < 32; r++) begin
      rs1_addr = 5'(r); rs2_addr = 5'(r);
      #1 check($sformatf("post_rst_x%0d", r), rs1_data | rs2_data, 32'h0);
    end
    // Writeback to a non-busy register after release.
    tick();
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h55;
    tick();
    idle(); rs1_addr = 5'd1;
    #1 check("late_wb_x1", rs1_data, 32'h55);
    check("late_wb_busy", busy_vec, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
